// File: rtl/fifo_ctrl_if.sv
// Handshake and status bundle between a FIFO controller and its user/RAM side.
interface fifo_ctrl_if #(
  parameter int unsigned ADDR_BITS = 3
);
  logic                 push;
  logic                 pop;
  logic                 write;
  logic                 read;
  logic [ADDR_BITS-1:0] addr_write;
  logic [ADDR_BITS-1:0] addr_read;
  logic                 data_valid;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [ADDR_BITS:0]   fifo_count;
  logic                 error;

  modport master (
    output push, pop,
    input  write, read, addr_write, addr_read, data_valid,
           full, empty, almost_full, almost_empty, fifo_count, error
  );

  modport slave (
    input  push, pop,
    output write, read, addr_write, addr_read, data_valid,
           full, empty, almost_full, almost_empty, fifo_count, error
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/occupancy controller for a FIFO built around an external RAM with
// 1-cycle read latency; the data path never passes through this block.
module fifo_ctrl #(
  parameter int unsigned ADDR_BITS       = 3,
  parameter int unsigned ALMOST_FULL_TH  = 6,
  parameter int unsigned ALMOST_EMPTY_TH = 2
) (
  input  logic       clk,
  input  logic       reset,
  fifo_ctrl_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam int unsigned CW    = ADDR_BITS + 1;

  logic [ADDR_BITS-1:0] r_wptr;
  logic [ADDR_BITS-1:0] r_rptr;
  logic [CW-1:0]        r_count;
  logic                 r_data_valid;
  logic                 r_error;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;

  // Flags decode only registered occupancy, so accept decisions never loop.
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push_ok = bus.push & ~w_full  & ~reset;
  assign w_pop_ok  = bus.pop  & ~w_empty & ~reset;

  assign bus.write        = w_push_ok;
  assign bus.read         = w_pop_ok;
  assign bus.addr_write   = r_wptr;
  assign bus.addr_read    = r_rptr;
  assign bus.data_valid   = r_data_valid;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= CW'(ALMOST_FULL_TH));
  assign bus.almost_empty = (r_count <= CW'(ALMOST_EMPTY_TH));
  assign bus.fifo_count   = r_count;
  assign bus.error        = r_error;

  // Pointers wrap naturally at DEPTH since they are exactly ADDR_BITS wide.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_data_valid <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + ADDR_BITS'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + ADDR_BITS'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_data_valid <= w_pop_ok;
      r_error      <= r_error | (bus.push & w_full) | (bus.pop & w_empty);
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a small behavioural RAM for data ordering.
module tb_fifo_ctrl;

  localparam int unsigned AB = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [11:0] data_in;
  logic [11:0] data_out;
  logic [11:0] ram [0:7];

  fifo_ctrl_if #(.ADDR_BITS(AB)) bus ();

  fifo_ctrl #(
    .ADDR_BITS(AB),
    .ALMOST_FULL_TH(6),
    .ALMOST_EMPTY_TH(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // RAM with registered read port, driven by the controller strobes
  always_ff @(posedge clk) begin
    if (bus.write) ram[bus.addr_write] <= data_in;
    if (bus.read)  data_out <= ram[bus.addr_read];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic p, input logic q);
    bus.push = p;
    bus.pop  = q;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    data_in = '0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    #2;
    // Strobes must stay low while reset is asserted, even with requests high
    drive(1'b1, 1'b1);
    check("rst_write", 32'(bus.write), 32'd0);
    check("rst_read",  32'(bus.read),  32'd0);
    tick();
    drive(1'b0, 1'b0);
    tick();
    reset = 1'b0;
    check("rst_empty",  32'(bus.empty),        32'd1);
    check("rst_full",   32'(bus.full),         32'd0);
    check("rst_ae",     32'(bus.almost_empty), 32'd1);
    check("rst_af",     32'(bus.almost_full),  32'd0);
    check("rst_count",  32'(bus.fifo_count),   32'd0);
    check("rst_waddr",  32'(bus.addr_write),   32'd0);
    check("rst_raddr",  32'(bus.addr_read),    32'd0);
    check("rst_error",  32'(bus.error),        32'd0);
    check("rst_dv",     32'(bus.data_valid),   32'd0);

    // Fill
    for (int i = 0; i < 8; i++) begin
      data_in = 12'(i + 1);
      drive(1'b1, 1'b0);
      check("fill_write", 32'(bus.write),      32'd1);
      check("fill_waddr", 32'(bus.addr_write), 32'(i));
      tick();
      check("fill_count", 32'(bus.fifo_count),  32'(i + 1));
      check("fill_af",    32'(bus.almost_full), 32'((i + 1) >= 6));
      check("fill_full",  32'(bus.full),        32'((i + 1) == 8));
      check("fill_error", 32'(bus.error),       32'd0);
    end

    // Overflow
    data_in = 12'hFFF;
    drive(1'b1, 1'b0);
    check("ovf_write", 32'(bus.write), 32'd0);
    tick();
    check("ovf_count", 32'(bus.fifo_count), 32'd8);
    check("ovf_error", 32'(bus.error),      32'd1);
    drive(1'b0, 1'b0);
    tick();
    check("ovf_sticky", 32'(bus.error), 32'd1);

    // Drain and ordering
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1);
      check("drn_read",  32'(bus.read),      32'd1);
      check("drn_raddr", 32'(bus.addr_read), 32'(i));
      tick();
      check("drn_count", 32'(bus.fifo_count),   32'(7 - i));
      check("drn_dv",    32'(bus.data_valid),   32'd1);
      check("drn_data",  32'(data_out),         32'(i + 1));
      check("drn_ae",    32'(bus.almost_empty), 32'((7 - i) <= 2));
    end
    check("drn_empty", 32'(bus.empty), 32'd1);
    drive(1'b0, 1'b0);
    tick();
    check("drn_dv_off", 32'(bus.data_valid), 32'd0);

    // Wrap: push 5, pop 5, push 6
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b0); tick(); end
    for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b1); tick(); end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0);
      check("wrap_waddr", 32'(bus.addr_write), 32'((5 + i) % 8));
      tick();
    end
    drive(1'b0, 1'b0);
    check("wrap_raddr", 32'(bus.addr_read),  32'd5);
    check("wrap_count", 32'(bus.fifo_count), 32'd6);
    check("wrap_full",  32'(bus.full),       32'd0);

    // Simultaneous at count 3, then at empty
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0); tick(); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1);
      check("sim_write", 32'(bus.write), 32'd1);
      check("sim_read",  32'(bus.read),  32'd1);
      check("sim_addr_differ", 32'(bus.addr_write != bus.addr_read), 32'd1);
      tick();
      check("sim_count", 32'(bus.fifo_count), 32'd3);
      check("sim_error", 32'(bus.error),      32'd0);
    end
    for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b1); tick(); end
    check("sim_empty", 32'(bus.empty), 32'd1);
    drive(1'b1, 1'b1);
    check("sim0_read",  32'(bus.read),  32'd0);
    check("sim0_write", 32'(bus.write), 32'd1);
    tick();
    check("sim0_count", 32'(bus.fifo_count), 32'd1);
    check("sim0_error", 32'(bus.error),      32'd1);
    check("sim0_dv",    32'(bus.data_valid), 32'd0);

    // Simultaneous while full: pop wins, push dropped
    do_reset();
    for (int i = 0; i < 8; i++) begin drive(1'b1, 1'b0); tick(); end
    drive(1'b1, 1'b1);
    check("simf_write", 32'(bus.write), 32'd0);
    check("simf_read",  32'(bus.read),  32'd1);
    tick();
    check("simf_count", 32'(bus.fifo_count), 32'd7);
    check("simf_error", 32'(bus.error),      32'd1);

    // Reset mid-stream with pop pending
    do_reset();
    for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b0); tick(); end
    drive(1'b0, 1'b1);
    tick();
    check("mid_dv_pre", 32'(bus.data_valid), 32'd1);
    reset = 1'b1;
    drive(1'b0, 1'b1);
    check("mid_read_rst", 32'(bus.read), 32'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0);
    check("mid_count", 32'(bus.fifo_count), 32'd0);
    check("mid_empty", 32'(bus.empty),      32'd1);
    check("mid_dv",    32'(bus.data_valid), 32'd0);
    check("mid_error", 32'(bus.error),      32'd0);
    check("mid_waddr", 32'(bus.addr_write), 32'd0);
    check("mid_raddr", 32'(bus.addr_read),  32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
